// File: rtl/lcd_char_driver_if.sv
// Display-content and LCD bus bundle for lcd_char_driver.
// master = the driver; slave = content source plus LCD panel.
interface lcd_char_driver_if;
   logic [7:0] char_in;
   logic [4:0] index;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_data;
   logic       init_done;
   logic       frame_done;

   modport master (
      input  char_in,
      output index, lcd_e, lcd_rs, lcd_rw,
      output lcd_data, init_done, frame_done
   );

   modport slave (
      output char_in,
      input  index, lcd_e, lcd_rs, lcd_rw,
      input  lcd_data, init_done, frame_done
   );
endinterface

// File: rtl/lcd_char_driver.sv
// HD44780 16x2 driver: power-on wait, init commands, then a
// continuous two-line refresh fetched from a 32-entry source.
module lcd_char_driver #(
   parameter int T_PWR    = 750000,
   parameter int T_SETUP  = 2,
   parameter int T_E      = 12,
   parameter int T_CMD    = 2000,
   parameter int T_CLR    = 82000,
   parameter int CHAR_LAT = 2,
   parameter int CW       = 20
) (
   input logic               clk,
   input logic               rst,
   lcd_char_driver_if.master bus
);
   // Step numbering: 0-6 init, 7 = cmd 80, 8-23 line 1,
   // 24 = cmd C0, 25-40 line 2.
   localparam logic [5:0] SEQ_FRAME = 6'd7;
   localparam logic [5:0] SEQ_INIT  = 6'd6;
   localparam logic [5:0] SEQ_LAST  = 6'd40;

   typedef enum logic [2:0] {
      PWR_WAIT, FETCH, SETUP, PULSE, HOLD
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [5:0]    seq, seq_n, lseq;
   logic [4:0]    idx_q, idx_n;
   logic [7:0]    data_q, data_n;
   logic          rs_q, rs_n;
   logic          e_q, e_n;
   logic          init_q, init_n;
   logic          fd_q, fd_n;
   logic          launch, cnt_z;

   function automatic logic is_data(logic [5:0] s);
      return (s >= 6'd8 && s <= 6'd23) || s >= 6'd25;
   endfunction

   function automatic logic [4:0] data_idx(logic [5:0] s);
      return (s <= 6'd23) ? 5'(s - 6'd8) : 5'(s - 6'd9);
   endfunction

   function automatic logic [7:0] cmd_byte(logic [5:0] s);
      logic [7:0] b;
      case (s)
         6'd0, 6'd1, 6'd2, 6'd3: b = 8'h38;
         6'd4:    b = 8'h0C;
         6'd5:    b = 8'h01;
         6'd6:    b = 8'h06;
         6'd7:    b = 8'h80;
         6'd24:   b = 8'hC0;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      seq_n   = seq;
      idx_n   = idx_q;
      data_n  = data_q;
      rs_n    = rs_q;
      init_n  = init_q;
      fd_n    = 1'b0;
      launch  = 1'b0;
      lseq    = seq;
      cnt_z   = (cnt == '0);

      case (state)
         PWR_WAIT: begin
            // Counts up from the reset value of 0.
            if (cnt == CW'(T_PWR - 1)) begin
               launch = 1'b1;
               lseq   = 6'd0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         FETCH: begin
            if (cnt_z) begin
               state_n = SETUP;
               cnt_n   = CW'(T_SETUP - 1);
               data_n  = bus.char_in;
               rs_n    = 1'b1;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         SETUP: begin
            if (cnt_z) begin
               state_n = PULSE;
               cnt_n   = CW'(T_E - 1);
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         PULSE: begin
            if (cnt_z) begin
               state_n = HOLD;
               cnt_n   = (!rs_q && data_q == 8'h01) ?
                         CW'(T_CLR - 1) : CW'(T_CMD - 1);
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         HOLD: begin
            if (cnt_z) begin
               launch = 1'b1;
               lseq   = (seq == SEQ_LAST) ? SEQ_FRAME : seq + 6'd1;
               if (seq == SEQ_INIT) init_n = 1'b1;
               if (seq == SEQ_LAST) fd_n = 1'b1;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         default: state_n = PWR_WAIT;
      endcase

      if (launch) begin
         seq_n = lseq;
         if (is_data(lseq)) begin
            state_n = FETCH;
            cnt_n   = CW'(CHAR_LAT - 1);
            idx_n   = data_idx(lseq);
         end else begin
            state_n = SETUP;
            cnt_n   = CW'(T_SETUP - 1);
            rs_n    = 1'b0;
            data_n  = cmd_byte(lseq);
         end
      end

      e_n = (state_n == PULSE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= PWR_WAIT;
         cnt    <= '0;
         seq    <= '0;
         idx_q  <= '0;
         data_q <= '0;
         rs_q   <= 1'b0;
         e_q    <= 1'b0;
         init_q <= 1'b0;
         fd_q   <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         seq    <= seq_n;
         idx_q  <= idx_n;
         data_q <= data_n;
         rs_q   <= rs_n;
         e_q    <= e_n;
         init_q <= init_n;
         fd_q   <= fd_n;
      end
   end

   assign bus.index      = idx_q;
   assign bus.lcd_e      = e_q;
   assign bus.lcd_rs     = rs_q;
   assign bus.lcd_rw     = 1'b0;
   assign bus.lcd_data   = data_q;
   assign bus.init_done  = init_q;
   assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_lcd_char_driver.sv
// Bench for lcd_char_driver: byte stream, strobe timing,
// frame wrap, sampling latency and mid-write reset.
module tb_lcd_char_driver;
   localparam int T_PWR    = 10;
   localparam int T_SETUP  = 2;
   localparam int T_E      = 3;
   localparam int T_CMD    = 5;
   localparam int T_CLR    = 9;
   localparam int CHAR_LAT = 2;
   localparam int FRAMES   = 4;
   localparam int TMO      = 400;

   logic clk = 1'b0;
   logic rst = 1'b1;

   lcd_char_driver_if bus ();

   lcd_char_driver #(
      .T_PWR(T_PWR), .T_SETUP(T_SETUP), .T_E(T_E),
      .T_CMD(T_CMD), .T_CLR(T_CLR), .CHAR_LAT(CHAR_LAT),
      .CW(20)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic       rs;
      logic       rw;
      logic [7:0] data;
      int         idx;
      int         gap;
      logic       init_done;
      int         fc;
   } wr_t;

   typedef struct {
      int len;
      int idx;
   } hi_t;

   typedef struct {
      logic       rs;
      logic [7:0] data;
   } vec_t;

   typedef struct {
      string name;
      int    exp;
   } rv_t;

   wr_t        wr_q[$];
   hi_t        hi_q[$];
   int         fd_q[$];
   int         frame_cnt;
   int         n_chk;
   int         n_fail;
   bit         dead;
   logic [7:0] rnd_tab[32];
   vec_t       init_tab[7];
   rv_t        rst_tab[7];

   initial forever #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Content source: frame 2 patches index 5, frames 3+ are random.
   function automatic logic [7:0] content(int f, int i);
      if (f == 2 && i == 5) return 8'h20;
      if (f >= 3) return rnd_tab[i];
      return 8'(8'h41 + i);
   endfunction

   initial begin
      bus.char_in = 8'h00;
      forever begin
         @(posedge clk);
         bus.char_in <= content(frame_cnt, int'(bus.index));
      end
   end

   // Monitor: logs each E rise, E-high length and frame_done runs.
   initial begin
      logic ep, fp;
      int   gap, hi, fl;
      wr_t  w;
      hi_t  h;
      ep = 1'b0; fp = 1'b0;
      gap = 0; hi = 0; fl = 0;
      frame_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            wr_q.delete();
            hi_q.delete();
            fd_q.delete();
            frame_cnt = 0;
            gap = 0; hi = 0; fl = 0;
            ep = bus.lcd_e;
            fp = bus.frame_done;
         end else begin
            if (bus.lcd_e && !ep) begin
               w.rs        = bus.lcd_rs;
               w.rw        = bus.lcd_rw;
               w.data      = bus.lcd_data;
               w.idx       = int'(bus.index);
               w.gap       = gap;
               w.init_done = bus.init_done;
               w.fc        = frame_cnt;
               wr_q.push_back(w);
               hi = 1;
            end else if (bus.lcd_e) begin
               hi++;
            end
            if (!bus.lcd_e && ep) begin
               h.len = hi;
               h.idx = int'(bus.index);
               hi_q.push_back(h);
               gap = 1;
            end else if (!bus.lcd_e) begin
               gap++;
            end
            if (bus.frame_done) begin
               if (!fp) frame_cnt++;
               fl++;
            end else if (fp) begin
               fd_q.push_back(fl);
               fl = 0;
            end
            ep = bus.lcd_e;
            fp = bus.frame_done;
         end
      end
   end

   task automatic chk(input string name, input int act,
                      input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h",
                  name, act, exp);
      end
   endtask

   function automatic int rd_reset(int i);
      case (i)
         0: return int'(bus.index);
         1: return int'(bus.lcd_e);
         2: return int'(bus.lcd_rs);
         3: return int'(bus.lcd_rw);
         4: return int'(bus.lcd_data);
         5: return int'(bus.init_done);
         default: return int'(bus.frame_done);
      endcase
   endfunction

   // Reference: n-th write after reset, from the sequence rules.
   task automatic exp_at(input int n, output logic rs,
                         output logic [7:0] d, output int idx,
                         output int f);
      int p;
      idx = -1;
      f   = 0;
      if (n < 7) begin
         rs = init_tab[n].rs;
         d  = init_tab[n].data;
      end else begin
         f = (n - 7) / 34;
         p = (n - 7) % 34;
         if (p == 0) begin
            rs = 1'b0; d = 8'h80;
         end else if (p == 17) begin
            rs = 1'b0; d = 8'hC0;
         end else begin
            idx = (p < 17) ? p - 1 : p - 2;
            rs  = 1'b1;
            d   = content(f, idx);
         end
      end
   endtask

   task automatic get_write(output wr_t w, output bit ok);
      int t = 0;
      while (wr_q.size() == 0 && t < TMO) begin
         @(negedge clk);
         t++;
      end
      ok = (wr_q.size() != 0);
      if (ok) begin
         w = wr_q.pop_front();
      end else begin
         n_chk++;
         n_fail++;
         dead = 1'b1;
         $display("FAIL write timeout: got none, expected E rise");
      end
   endtask

   task automatic check_write(input int n);
      wr_t        w;
      hi_t        h;
      bit         ok;
      logic       rs, prs;
      logic [7:0] d, pd;
      int         idx, pidx, f, pf, hold, t;
      string      tag;
      get_write(w, ok);
      if (!ok) return;
      tag = $sformatf("w%0d", n);
      exp_at(n, rs, d, idx, f);
      chk({tag, " data"}, int'(w.data), int'(d));
      chk({tag, " rs"}, int'(w.rs), int'(rs));
      chk({tag, " rw"}, int'(w.rw), 0);
      if (rs) chk({tag, " index@rise"}, w.idx, idx);
      if (n > 0) begin
         exp_at(n - 1, prs, pd, pidx, pf);
         hold = (!prs && pd == 8'h01) ? T_CLR : T_CMD;
         chk({tag, " gap"}, w.gap,
             hold + T_SETUP + (rs ? CHAR_LAT : 0));
      end
      if (n == 6) chk({tag, " init_done"}, int'(w.init_done), 0);
      if (n >= 7) chk({tag, " init_done"}, int'(w.init_done), 1);
      if (n >= 7 && !rs && d == 8'h80) begin
         chk({tag, " frame count"}, w.fc, f);
         if (f == 0) begin
            chk({tag, " early frame_done"}, fd_q.size(), 0);
         end else if (fd_q.size() == 0) begin
            chk({tag, " frame_done pulses"}, 0, 1);
         end else begin
            chk({tag, " frame_done width"}, fd_q.pop_front(), 1);
         end
      end
      t = 0;
      while (hi_q.size() == 0 && t < TMO) begin
         @(negedge clk);
         t++;
      end
      if (hi_q.size() == 0) begin
         chk({tag, " E fall"}, 0, 1);
         dead = 1'b1;
      end else begin
         h = hi_q.pop_front();
         chk({tag, " E width"}, h.len, T_E);
         if (rs) chk({tag, " index@fall"}, h.idx, idx);
      end
   endtask

   task automatic first_rise(input string tag);
      int n = 0;
      while (!bus.lcd_e && n < TMO) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " first E rise"}, n, T_PWR + T_SETUP);
   endtask

   initial begin
      int t;
      n_chk  = 0;
      n_fail = 0;
      dead   = 1'b0;
      init_tab = '{
         '{1'b0, 8'h38}, '{1'b0, 8'h38}, '{1'b0, 8'h38},
         '{1'b0, 8'h38}, '{1'b0, 8'h0C}, '{1'b0, 8'h01},
         '{1'b0, 8'h06}
      };
      rst_tab = '{
         '{"rst index", 0}, '{"rst lcd_e", 0},
         '{"rst lcd_rs", 0}, '{"rst lcd_rw", 0},
         '{"rst lcd_data", 0}, '{"rst init_done", 0},
         '{"rst frame_done", 0}
      };
      foreach (rnd_tab[i]) rnd_tab[i] = 8'($urandom_range(32, 126));

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 7; i++)
         chk(rst_tab[i].name, rd_reset(i), rst_tab[i].exp);
      #1 rst = 1'b0;
      first_rise("boot");

      for (int n = 0; n < 7 + 34 * FRAMES; n++) begin
         if (dead) break;
         check_write(n);
      end

      // Reset while E is high during the index-7 data write.
      t = 0;
      while (!(bus.lcd_e && bus.lcd_rs && bus.index == 5'd7)
             && t < 2000 && !dead) begin
         @(negedge clk);
         t++;
      end
      if (dead || t >= 2000) begin
         chk("idx7 write reached", 0, 1);
      end else begin
         rst = 1'b1;
         @(negedge clk);
         chk("midrst lcd_e", int'(bus.lcd_e), 0);
         chk("midrst init_done", int'(bus.init_done), 0);
         chk("midrst index", int'(bus.index), 0);
         chk("midrst lcd_data", int'(bus.lcd_data), 0);
         #1 rst = 1'b0;
         first_rise("restart");
         for (int n = 0; n < 7; n++) begin
            if (dead) break;
            check_write(n);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/lcd_char_driver.md
Name: lcd_char_driver

Overview:
- Consumer end of the 32-character display-content interface of the watch.
- Drives a 5-bit character index and samples the returned 8-bit ASCII code on `char_in`.
- Initialises an HD44780-compatible 16x2 character LCD over an 8-bit write-only bus, then refreshes both lines continuously.
- Index 0-15 maps to line 1 and index 16-31 to line 2.

Parameters:
- T_PWR, 750000: power-on wait in clk cycles before the first command (15 ms at 50 MHz).
- T_SETUP, 2: cycles RS/DATA are stable before E rises.
- T_E, 12: cycles E is held high.
- T_CMD, 2000: post-write wait for ordinary commands and data.
- T_CLR, 82000: post-write wait after the clear command 0x01.
- CHAR_LAT, 2: cycles between an index change and sampling `char_in`; must be ≥ source latency + 1.
- CW, 20: wait-counter width; must hold max(T_PWR, T_CLR).

Ports:
- clk in 1: system clock.
- rst in 1: synchronous, active-high reset.
- char_in in 8: ASCII code for the current `index`, supplied by the content generator.
- index out 5: character position requested, 0-31.
- lcd_e out 1: LCD enable strobe.
- lcd_rs out 1: 0 = command, 1 = data.
- lcd_rw out 1: constant 0 (write only).
- lcd_data out 8: LCD data bus.
- init_done out 1: high once the init sequence has completed.
- frame_done out 1: one-cycle pulse after the 32nd character write of each frame.

Behaviour:
- Reset is synchronous and active-high: on any clk edge with rst=1, all state is cleared regardless of the current state.
  - Reset values: index=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, init_done=0, frame_done=0.
  - FSM enters PWR_WAIT with the wait counter at 0.
  - A reset mid-write drops lcd_e on the next edge and restarts the full power-on/init sequence.
- Top-level sequence:
  1. PWR_WAIT: count T_PWR cycles.
  2. Init commands, in order, all with RS=0: 38,38,38,38,0C,01,06 (hex).
  3. Set init_done=1; it stays high until reset.
  4. Frame loop: cmd 80, data idx 0..15, cmd C0, data idx 16..31.
  5. Pulse frame_done, then repeat from cmd 80 indefinitely.
- Write cycle, used for every command and data byte:
  - SETUP: lcd_rs and lcd_data are driven, lcd_e=0, for T_SETUP cycles.
  - PULSE: lcd_e=1 for exactly T_E cycles.
  - HOLD: lcd_e=0 for T_CLR cycles after byte 01, otherwise T_CMD cycles.
  - lcd_rs and lcd_data stay unchanged from SETUP entry through the end of HOLD.
- Data fetch: before each data write the FSM enters FETCH.
  - On FETCH entry, index is set to k.
  - FETCH waits CHAR_LAT cycles; on the transition to SETUP, char_in is latched into lcd_data.
  - index then holds k until the next FETCH; command writes never change index.
- Counter rule: one shared CW-bit down-counter, loaded with N-1 on state entry. The state exits when the counter reads 0, so each state lasts exactly N cycles.
- frame_done asserts for exactly one cycle, on the cycle HOLD of idx 31 ends. That is the same cycle SETUP of cmd 80 begins.
- char_in is sampled only at FETCH→SETUP; changes at any other time have no effect.
- No back-pressure and no busy-flag read; all timing is open-loop by cycle count.

Test Plan (bench uses small parameters: T_PWR=10, T_SETUP=2, T_E=3, T_CMD=5, T_CLR=9, CHAR_LAT=2; the content model is a 1-cycle registered lookup returning 8'h41+index):
- Reset check: hold rst=1 for 3 cycles, then release → all outputs read the reset values above, and the first lcd_e rise occurs 10+2 cycles after release.
- Init sequence: capture lcd_data on each lcd_e rise → 38,38,38,38,0C,01,06, all with rs=0, rw always 0.
  - Each E-high lasts 3 cycles.
  - The gap from the fall of E after 01 to the next rise of E is 9+2 cycles; every other such gap is 5+2.
  - init_done rises after the 06 HOLD.
- Frame content: capture one frame → 80 (rs=0), then 16 bytes 41..50 (rs=1), then C0 (rs=0), then 16 bytes 51..60 (rs=1).
  - index equals the byte position throughout each data write.
- Wrap: after the idx 31 write, frame_done is high for exactly 1 cycle, the next captured byte is 80 with rs=0, and the next data byte has index 0 and value 41.
- Latency: change the model to return 8'h20 for index 5 on frame 2 only → frame 2 byte 6 is 20; no other bytes change.
- Mid-write reset: assert rst for 1 cycle while lcd_e=1 during idx 7 → lcd_e=0 on the next edge, init_done=0, and the sequence restarts with PWR_WAIT followed by 38.
